alu_arbiter: RTL and testbench

//  Shares one 8-bit add/sub ALU (a, b, f -> y, zero) between NREQ requesters.
//  - Arbitrates round-robin and registers the granted operands.
//  - Sequences one ALU operation and returns y/zero to the winner on a valid/ready response.
//  - Sits between the ALU instance and its clients (e.g. PC/branch unit, address calc).

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu_arb_rr_picker.sv | 45 ++++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, operation record, ALU opcodes
// and the modular index helper used by the requester picker.
package alu_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       f;
  } alu_op_t;

  localparam int   NREQ_MAX = 8;
  localparam logic ALU_ADD  = 1'b0;
  localparam logic ALU_SUB  = 1'b1;

  function automatic int wrapAdd(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/alu_arb_rr_picker.sv
// Combinational requester picker: one-hot grant plus index, searching upward from ptr_i.
// With ALU_ARB_FIXED_PRIO_EN defined the search always starts at 0 (lowest index wins).
module rr_picker
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic [PW-1:0] ptrEff;
  logic [PW-1:0] cand;
  logic          found;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unusedPtr;
  assign unusedPtr = ^ptr_i;
  assign ptrEff    = '0;
`else
  assign ptrEff = ptr_i;
`endif

  // First active requester at or after ptrEff, wrapping at NREQ-1 back to 0.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand = PW'(wrapAdd(int'(ptrEff), off, NREQ));
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one add/sub ALU between NREQ requesters: grant, execute, then hold the result until the
// winner takes it. Define ALU_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority instead of round robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]            req_f,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [WIDTH-1:0]           rsp_y,
  output logic                       rsp_zero,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic                       alu_f,
  input  logic [WIDTH-1:0]           alu_y,
  input  logic                       alu_zero
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_nreq_check
    $error("alu_arbiter: NREQ must be in 2..NREQ_MAX");
  end

  arb_state_e      state_q;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic            f_q, zero_q;
  logic [NREQ-1:0] rsp_valid_q;

  logic [NREQ-1:0] pickGnt;
  logic [PW-1:0]   pickIdx;
  logic            pickAny;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pickGnt),
    .idx_o (pickIdx),
    .any_o (pickAny)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr_d = '0;
`else
  assign ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
`endif

  // Gated by reset_n so the acceptance strobe is silent while reset is held.
  assign req_ready = (state_q == IDLE && reset_n) ? pickGnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = y_q;
  assign rsp_zero  = zero_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_f     = f_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= ALU_ADD;
      y_q         <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pickAny) begin
            a_q     <= req_a[pickIdx];
            b_q     <= req_b[pickIdx];
            f_q     <= req_f[pickIdx] ? ALU_SUB : ALU_ADD;
            gnt_q   <= pickIdx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          y_q         <= alu_y;
          zero_q      <= alu_zero;
          rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
          state_q     <= RESP;
        end
        RESP: begin
          // Only the granted requester can retire the result.
          if (rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural add/sub ALU attached.
// Contention expectations follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 8;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0]            req_f;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0]            rsp_ready;
  logic [WIDTH-1:0]           rsp_y;
  logic                       rsp_zero;
  logic [WIDTH-1:0]           alu_a;
  logic [WIDTH-1:0]           alu_b;
  logic                       alu_f;
  logic [WIDTH-1:0]           alu_y;
  logic                       alu_zero;

  int compared   = 0;
  int mismatched = 0;

  logic [1:0] expGnt [4];
  logic [7:0] expY;

  alu_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_f     (req_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero)
  );

  always #5 clk = ~clk;

  // Stand-in for the real ALU: modulo-2^WIDTH add/sub, zero when the operands match.
  assign alu_y    = alu_f ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_zero = (alu_a == alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b, input logic f);
    req_a[idx] = a;
    req_b[idx] = b;
    req_f[idx] = f;
  endtask

  task automatic runOp(input int idx, input logic [7:0] a, input logic [7:0] b, input logic f,
                       input logic [7:0] y, input logic z, input string tag);
    applyStimulus(idx, a, b, f);
    req_valid = 2'b01 << idx;
    #1;
    checkOutput({tag, ".req_ready"}, req_ready, 2'b01 << idx);
    tick();
    req_valid = '0;
    #1;
    checkOutput({tag, ".exec_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, ".alu_a"}, alu_a, a);
    checkOutput({tag, ".alu_b"}, alu_b, b);
    tick();
    checkOutput({tag, ".rsp_valid"}, rsp_valid, 2'b01 << idx);
    checkOutput({tag, ".rsp_y"}, rsp_y, y);
    checkOutput({tag, ".rsp_zero"}, rsp_zero, z);
    rsp_ready = 2'b01 << idx;
    tick();
    rsp_ready = '0;
    checkOutput({tag, ".done_rsp_valid"}, rsp_valid, 0);
  endtask

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    expGnt[0] = 2'b01; expGnt[1] = 2'b01; expGnt[2] = 2'b01; expGnt[3] = 2'b01;
`else
    expGnt[0] = 2'b01; expGnt[1] = 2'b10; expGnt[2] = 2'b01; expGnt[3] = 2'b10;
`endif

    reset_n   = 1'b0;
    req_valid = 2'b01;
    req_a     = '0;
    req_b     = '0;
    req_f     = '0;
    rsp_ready = '0;
    #3;
    checkOutput("rst.req_ready", req_ready, 0);
    checkOutput("rst.rsp_valid", rsp_valid, 0);
    checkOutput("rst.rsp_y", rsp_y, 0);
    checkOutput("rst.alu_a", alu_a, 0);
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single add, then subtract to zero and subtract with wrap.
    runOp(0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, "add");
    runOp(1, 8'h2A, 8'h2A, 1'b1, 8'h00, 1'b1, "subEq");
    runOp(1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, "subWrap");

    // Both requesters held valid across four operations.
    applyStimulus(0, 8'h10, 8'h01, 1'b0);
    applyStimulus(1, 8'h20, 8'h03, 1'b1);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("cont%0d.req_ready", k), req_ready, expGnt[k]);
      tick();
      checkOutput($sformatf("cont%0d.exec_req_ready", k), req_ready, 0);
      tick();
      expY = (expGnt[k] == 2'b01) ? 8'h11 : 8'h1D;
      checkOutput($sformatf("cont%0d.rsp_valid", k), rsp_valid, expGnt[k]);
      checkOutput($sformatf("cont%0d.rsp_y", k), rsp_y, expY);
      rsp_ready = 2'b11;
      tick();
      rsp_ready = '0;
    end
    req_valid = '0;

    // Backpressure on requester 0 with a stray ready from requester 1.
    applyStimulus(0, 8'h07, 8'h09, 1'b0);
    applyStimulus(1, 8'h20, 8'h03, 1'b1);
    req_valid = 2'b11;
    #1;
    checkOutput("bp.req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    tick();
    for (int c = 0; c < 5; c++) begin
      rsp_ready = (c == 2) ? 2'b10 : 2'b00;
      #1;
      checkOutput($sformatf("bp%0d.rsp_valid", c), rsp_valid, 2'b01);
      checkOutput($sformatf("bp%0d.rsp_y", c), rsp_y, 8'h10);
      checkOutput($sformatf("bp%0d.rsp_zero", c), rsp_zero, 0);
      checkOutput($sformatf("bp%0d.req_ready", c), req_ready, 0);
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    #1;
    checkOutput("bp.next_req_ready", req_ready, 2'b10);
    checkOutput("bp.idle_rsp_valid", rsp_valid, 0);
    tick();
    req_valid = '0;
    tick();
    checkOutput("bp.req1_rsp_valid", rsp_valid, 2'b10);
    checkOutput("bp.req1_rsp_y", rsp_y, 8'h1D);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;

    // Reset while a result is pending in RESP.
    runOp(0, 8'h01, 8'h01, 1'b1, 8'h00, 1'b1, "preRst");
    applyStimulus(0, 8'h05, 8'h03, 1'b0);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    checkOutput("mid.rsp_valid", rsp_valid, 2'b01);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("mid.rst_rsp_valid", rsp_valid, 0);
    checkOutput("mid.rst_rsp_y", rsp_y, 0);
    checkOutput("mid.rst_rsp_zero", rsp_zero, 0);
    checkOutput("mid.rst_alu_a", alu_a, 0);
    checkOutput("mid.rst_alu_b", alu_b, 0);
    checkOutput("mid.rst_alu_f", alu_f, 0);
    checkOutput("mid.rst_req_ready", req_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    req_valid = 2'b11;
    #1;
    checkOutput("post.both_req_ready", req_ready, 2'b01);
    req_valid = 2'b10;
    #1;
    checkOutput("post.req1_req_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    tick();
    checkOutput("post.rsp_valid", rsp_valid, 2'b10);
    checkOutput("post.rsp_y", rsp_y, 8'h1D);
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;
    checkOutput("post.done_rsp_valid", rsp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
